// File: rtl/fp_writeback_arbiter_if.sv
// Handshake and bus bundle between the FP result producers, issue logic, CSR unit
// and the FP writeback arbiter. Signal prefixes are from the arbiter's point of view.
interface fp_writeback_arbiter_if #(
    parameter int FLEN  = 32,
    parameter int N_SRC = 3
);
    logic [N_SRC-1:0]      i_src_valid;
    logic [N_SRC-1:0]      o_src_ready;
    logic [N_SRC*5-1:0]    i_src_rd;
    logic [N_SRC*FLEN-1:0] i_src_data;
    logic [N_SRC*5-1:0]    i_src_flags;
    logic [4:0]            o_rd;
    logic [FLEN-1:0]       o_rd_din;
    logic                  o_reg_write;
    logic                  i_issue_valid;
    logic [4:0]            i_issue_rd;
    logic [14:0]           i_issue_rs;
    logic [2:0]            i_issue_rs_used;
    logic                  o_issue_stall;
    logic [31:0]           o_pending;
    logic                  i_fflags_clr;
    logic [4:0]            o_fflags;

    modport slave (
        input  i_src_valid, i_src_rd, i_src_data, i_src_flags,
        input  i_issue_valid, i_issue_rd, i_issue_rs, i_issue_rs_used, i_fflags_clr,
        output o_src_ready, o_rd, o_rd_din, o_reg_write, o_issue_stall, o_pending, o_fflags
    );

    modport master (
        output i_src_valid, i_src_rd, i_src_data, i_src_flags,
        output i_issue_valid, i_issue_rd, i_issue_rs, i_issue_rs_used, i_fflags_clr,
        input  o_src_ready, o_rd, o_rd_din, o_reg_write, o_issue_stall, o_pending, o_fflags
    );
endinterface

// File: rtl/fp_writeback_arbiter.sv
// FP register-file write arbiter: fixed-priority producer select, registered write
// port, 32-entry pending scoreboard for RAW/WAW issue stalls, sticky fflags.
module fp_writeback_arbiter #(
    parameter int FLEN  = 32,
    parameter int N_SRC = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fp_writeback_arbiter_if.slave wb
);
    logic [N_SRC-1:0] w_ready;
    logic             w_seen;
    logic             w_accept;
    logic [4:0]       w_rd;
    logic [FLEN-1:0]  w_data;
    logic [4:0]       w_flags;
    logic             w_rs_hit;
    logic             w_stall;
    logic [31:0]      w_clr_mask;
    logic [31:0]      w_set_mask;
    logic [31:0]      w_pending_nxt;
    logic [4:0]       w_fflags_nxt;

    logic             r_reg_write;
    logic [4:0]       r_rd;
    logic [FLEN-1:0]  r_rd_din;
    logic [31:0]      r_pending;
    logic [4:0]       r_fflags;

    // Fixed-priority one-hot select and winner mux; nothing is accepted while in reset
    always_comb begin
        w_ready = {N_SRC{1'b0}};
        w_seen  = 1'b0;
        w_rd    = 5'd0;
        w_data  = {FLEN{1'b0}};
        w_flags = 5'd0;
        for (int k = 0; k < N_SRC; k++) begin
            w_ready[k] = wb.i_src_valid[k] & ~w_seen & i_rst_n;
            w_seen     = w_seen | wb.i_src_valid[k];
            w_rd       = w_rd    | ({5{w_ready[k]}}    & wb.i_src_rd[5*k +: 5]);
            w_data     = w_data  | ({FLEN{w_ready[k]}} & wb.i_src_data[FLEN*k +: FLEN]);
            w_flags    = w_flags | ({5{w_ready[k]}}    & wb.i_src_flags[5*k +: 5]);
        end
        w_accept = |w_ready;
    end

    // Hazard check against current pending bits, and next-state of scoreboard/fflags
    always_comb begin
        w_rs_hit = (wb.i_issue_rs_used[0] & r_pending[wb.i_issue_rs[4:0]])
                 | (wb.i_issue_rs_used[1] & r_pending[wb.i_issue_rs[9:5]])
                 | (wb.i_issue_rs_used[2] & r_pending[wb.i_issue_rs[14:10]]);
        w_stall  = wb.i_issue_valid & (r_pending[wb.i_issue_rd] | w_rs_hit);
        // set mask is applied after the clear so an issue to the same index wins
        w_clr_mask    = w_accept ? (32'd1 << w_rd) : 32'd0;
        w_set_mask    = (wb.i_issue_valid & ~w_stall) ? (32'd1 << wb.i_issue_rd) : 32'd0;
        w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
        w_fflags_nxt  = (wb.i_fflags_clr ? 5'd0 : r_fflags) | (w_accept ? w_flags : 5'd0);
    end

    // Registered write port, scoreboard and sticky flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_reg_write <= 1'b0;
            r_rd        <= 5'd0;
            r_rd_din    <= {FLEN{1'b0}};
            r_pending   <= 32'd0;
            r_fflags    <= 5'd0;
        end else begin
            r_reg_write <= w_accept;
            if (w_accept) begin
                r_rd     <= w_rd;
                r_rd_din <= w_data;
            end
            r_pending   <= w_pending_nxt;
            r_fflags    <= w_fflags_nxt;
        end
    end

    assign wb.o_src_ready   = w_ready;
    assign wb.o_rd          = r_rd;
    assign wb.o_rd_din      = r_rd_din;
    assign wb.o_reg_write   = r_reg_write;
    assign wb.o_issue_stall = w_stall;
    assign wb.o_pending     = r_pending;
    assign wb.o_fflags      = r_fflags;
endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed bench for fp_writeback_arbiter: arbitration order, write latency,
// scoreboard stalls, fflags accumulation/clear and mid-operation reset.
module tb_fp_writeback_arbiter;
    logic i_clk;
    logic i_rst_n;
    int   errors;
    int   checks;

    fp_writeback_arbiter_if #(.FLEN(32), .N_SRC(3)) bus ();

    fp_writeback_arbiter #(.FLEN(32), .N_SRC(3)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wb      (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        i_rst_n             = 1'b0;
        bus.i_src_valid     = 3'b000;
        bus.i_src_rd        = 15'd0;
        bus.i_src_data      = 96'd0;
        bus.i_src_flags     = 15'd0;
        bus.i_issue_valid   = 1'b0;
        bus.i_issue_rd      = 5'd0;
        bus.i_issue_rs      = 15'd0;
        bus.i_issue_rs_used = 3'b000;
        bus.i_fflags_clr    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_reg_write", bus.o_reg_write, 64'd0);
        chk("rst_rd",        bus.o_rd,        64'd0);
        chk("rst_din",       bus.o_rd_din,    64'd0);
        chk("rst_pending",   bus.o_pending,   64'd0);
        chk("rst_fflags",    bus.o_fflags,    64'd0);
        i_rst_n = 1'b1;
        tick();

        // 1. single FMA result
        bus.i_src_valid = 3'b010;
        bus.i_src_rd    = {5'd0, 5'd5, 5'd0};
        bus.i_src_data  = {32'd0, 32'h3F80_0000, 32'd0};
        bus.i_src_flags = {5'd0, 5'b00001, 5'd0};
        #1;
        chk("t1_ready", bus.o_src_ready, 64'b010);
        tick();
        bus.i_src_valid = 3'b000;
        chk("t1_reg_write", bus.o_reg_write, 64'd1);
        chk("t1_rd",        bus.o_rd,        64'd5);
        chk("t1_din",       bus.o_rd_din,    64'h3F80_0000);
        chk("t1_fflags",    bus.o_fflags,    64'b00001);
        chk("t1_pending",   bus.o_pending,   64'd0);

        // 2. three producers at once, served in priority order back to back
        bus.i_src_valid = 3'b111;
        bus.i_src_rd    = {5'd12, 5'd11, 5'd10};
        bus.i_src_data  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        bus.i_src_flags = {5'b01000, 5'b00010, 5'b00000};
        #1;
        chk("t2_ready0", bus.o_src_ready, 64'b001);
        tick();
        chk("t2_w0_we",  bus.o_reg_write, 64'd1);
        chk("t2_w0_rd",  bus.o_rd,        64'd10);
        chk("t2_w0_din", bus.o_rd_din,    64'hAAAA_0000);
        bus.i_src_valid = 3'b110;
        #1;
        chk("t2_ready1", bus.o_src_ready, 64'b010);
        tick();
        chk("t2_w1_we",  bus.o_reg_write, 64'd1);
        chk("t2_w1_rd",  bus.o_rd,        64'd11);
        chk("t2_w1_din", bus.o_rd_din,    64'hBBBB_0001);
        bus.i_src_valid = 3'b100;
        #1;
        chk("t2_ready2", bus.o_src_ready, 64'b100);
        tick();
        bus.i_src_valid = 3'b000;
        chk("t2_w2_we",  bus.o_reg_write, 64'd1);
        chk("t2_w2_rd",  bus.o_rd,        64'd12);
        chk("t2_w2_din", bus.o_rd_din,    64'hCCCC_0002);
        chk("t2_fflags", bus.o_fflags,    64'b01011);
        tick();
        chk("t2_idle_we",  bus.o_reg_write, 64'd0);
        chk("t2_hold_rd",  bus.o_rd,        64'd12);
        chk("t2_hold_din", bus.o_rd_din,    64'hCCCC_0002);

        // 3. RAW on rs1
        bus.i_src_flags     = 15'd0;
        bus.i_issue_valid   = 1'b1;
        bus.i_issue_rd      = 5'd7;
        bus.i_issue_rs_used = 3'b000;
        #1;
        chk("t3_issue7_stall", bus.o_issue_stall, 64'd0);
        tick();
        chk("t3_pend7", bus.o_pending, 64'h0000_0080);
        bus.i_issue_rd      = 5'd8;
        bus.i_issue_rs      = {5'd0, 5'd0, 5'd7};
        bus.i_issue_rs_used = 3'b001;
        #1;
        chk("t3_raw_stall", bus.o_issue_stall, 64'd1);
        tick();
        chk("t3_raw_stall_hold", bus.o_issue_stall, 64'd1);
        chk("t3_pend_hold",      bus.o_pending,     64'h0000_0080);
        bus.i_src_valid = 3'b100;
        bus.i_src_rd    = {5'd7, 5'd0, 5'd0};
        bus.i_src_data  = {32'h4000_0000, 32'd0, 32'd0};
        #1;
        chk("t3_clearing_stall", bus.o_issue_stall, 64'd1);
        chk("t3_ready2",         bus.o_src_ready,   64'b100);
        tick();
        bus.i_src_valid = 3'b000;
        chk("t3_wb_we",     bus.o_reg_write,   64'd1);
        chk("t3_wb_rd",     bus.o_rd,          64'd7);
        chk("t3_wb_pend",   bus.o_pending,     64'd0);
        chk("t3_wb_nostall", bus.o_issue_stall, 64'd0);
        tick();
        chk("t3_pend8", bus.o_pending, 64'h0000_0100);
        bus.i_issue_rd      = 5'd9;
        bus.i_issue_rs      = {5'd0, 5'd0, 5'd8};
        bus.i_issue_rs_used = 3'b000;
        #1;
        chk("t3_unused_nostall", bus.o_issue_stall, 64'd0);
        bus.i_issue_rs      = {5'd0, 5'd8, 5'd0};
        bus.i_issue_rs_used = 3'b010;
        #1;
        chk("t3_rs2_stall", bus.o_issue_stall, 64'd1);
        bus.i_issue_valid   = 1'b0;
        bus.i_issue_rs_used = 3'b000;
        bus.i_src_valid     = 3'b001;
        bus.i_src_rd        = {5'd0, 5'd0, 5'd8};
        tick();
        bus.i_src_valid = 3'b000;
        chk("t3_pend_clr8", bus.o_pending, 64'd0);

        // 4. WAW
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd3;
        tick();
        chk("t4_pend3", bus.o_pending, 64'h0000_0008);
        #1;
        chk("t4_waw_stall", bus.o_issue_stall, 64'd1);
        bus.i_issue_rd = 5'd4;
        #1;
        chk("t4_rd4_nostall", bus.o_issue_stall, 64'd0);
        tick();
        bus.i_issue_valid = 1'b0;
        chk("t4_pend34", bus.o_pending, 64'h0000_0018);
        bus.i_src_valid = 3'b010;
        bus.i_src_rd    = {5'd0, 5'd3, 5'd0};
        tick();
        chk("t4_wb_rd", bus.o_rd,      64'd3);
        chk("t4_pend4", bus.o_pending, 64'h0000_0010);
        // same-index set and clear: set wins
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd20;
        bus.i_src_valid   = 3'b001;
        bus.i_src_rd      = {5'd0, 5'd0, 5'd20};
        #1;
        chk("t4_rd20_nostall", bus.o_issue_stall, 64'd0);
        tick();
        bus.i_issue_valid = 1'b0;
        bus.i_src_valid   = 3'b000;
        chk("t4_set_wins", bus.o_pending, 64'h0010_0010);

        // 5. fflags clear interplay
        bus.i_fflags_clr = 1'b1;
        tick();
        chk("t5_clr0", bus.o_fflags, 64'd0);
        bus.i_fflags_clr = 1'b0;
        bus.i_src_valid  = 3'b001;
        bus.i_src_rd     = {5'd0, 5'd0, 5'd1};
        bus.i_src_flags  = {5'd0, 5'd0, 5'b10000};
        tick();
        chk("t5_nv", bus.o_fflags, 64'b10000);
        bus.i_fflags_clr = 1'b1;
        bus.i_src_valid  = 3'b010;
        bus.i_src_rd     = {5'd0, 5'd2, 5'd0};
        bus.i_src_flags  = {5'd0, 5'b00100, 5'd0};
        tick();
        chk("t5_clr_accept", bus.o_fflags, 64'b00100);
        bus.i_src_valid = 3'b000;
        tick();
        chk("t5_clr_alone", bus.o_fflags, 64'd0);
        bus.i_fflags_clr = 1'b0;

        // 6. reset mid-operation
        bus.i_issue_valid = 1'b1;
        bus.i_issue_rd    = 5'd1;
        bus.i_src_valid   = 3'b001;
        bus.i_src_rd      = {5'd0, 5'd0, 5'd9};
        bus.i_src_flags   = {5'd0, 5'd0, 5'b00010};
        tick();
        bus.i_src_valid = 3'b000;
        bus.i_issue_rd  = 5'd2;
        tick();
        bus.i_issue_valid = 1'b0;
        chk("t6_pend_pre",   bus.o_pending, 64'h0010_0016);
        chk("t6_fflags_pre", bus.o_fflags,  64'b00010);
        i_rst_n         = 1'b0;
        bus.i_src_valid = 3'b100;
        bus.i_src_rd    = {5'd30, 5'd0, 5'd0};
        bus.i_src_data  = {32'h1234_5678, 32'd0, 32'd0};
        bus.i_src_flags = {5'b10000, 5'd0, 5'd0};
        tick();
        chk("t6_rst_pend",   bus.o_pending,   64'd0);
        chk("t6_rst_fflags", bus.o_fflags,    64'd0);
        chk("t6_rst_we",     bus.o_reg_write, 64'd0);
        i_rst_n = 1'b1;
        #1;
        chk("t6_represent_ready", bus.o_src_ready, 64'b100);
        tick();
        bus.i_src_valid = 3'b000;
        chk("t6_after_we",     bus.o_reg_write, 64'd1);
        chk("t6_after_rd",     bus.o_rd,        64'd30);
        chk("t6_after_din",    bus.o_rd_din,    64'h1234_5678);
        chk("t6_after_fflags", bus.o_fflags,    64'b10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
